router_fifo: RTL and testbench

- One of three identical output FIFOs in the 1x3 packet router.
- Buffers bytes written by the router FSM/synchronizer and drains them to the destination client.
- Each stored word carries a header-marker bit (lfd_state) so the read side can track packet length.
- Drives the output bus only while a packet is being read out.

---
 rtl/router_pkg.sv | 27 ++
 rtl/router_fifo.sv | 76 +++++++
 tb/tb_router_fifo.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/router_pkg.sv
// Shared sizing and header-field layout for the 1x3 packet router output FIFOs.
package router_pkg;

  localparam int DEPTH   = 16;
  localparam int DATA_W  = 8;
  localparam int CNT_W   = 7;
  localparam int ADDR_W  = $clog2(DEPTH);
  localparam int PTR_W   = ADDR_W + 1;
  localparam int WORD_W  = DATA_W + 1;
  localparam int HDR_BIT = DATA_W;

  // Header byte layout: payload length in the upper six bits, destination in the lower two.
  localparam int LEN_MSB  = 7;
  localparam int LEN_LSB  = 2;
  localparam int DEST_MSB = 1;
  localparam int DEST_LSB = 0;

  // Bytes still to come after the header: payload plus the trailing parity byte.
  function automatic logic [CNT_W-1:0] hdr_len(input logic [DATA_W-1:0] hdr);
    return CNT_W'(hdr[LEN_MSB:LEN_LSB]) + CNT_W'(1);
  endfunction

  function automatic logic [DEST_MSB-DEST_LSB:0] hdr_dest(input logic [DATA_W-1:0] hdr);
    return hdr[DEST_MSB:DEST_LSB];
  endfunction

endpackage

// File: rtl/router_fifo.sv
// Router output FIFO with header-tracking packet counter; drives data_out_0 only while a packet drains.
// Optional FIFO_TRISTATE_OUT_EN: idle output is high-impedance instead of 8'h00.
module router_fifo
  import router_pkg::*;
(
  input  logic              clk,
  input  logic              rstn,
  input  logic              soft_rst_0,
  input  logic              wr_en_0,
  input  logic              rd_en_0,
  input  logic [DATA_W-1:0] data_in,
  input  logic              lfd_state,
  output logic              empty,
  output logic [DATA_W-1:0] data_out_0,
  output logic              full
);

`ifdef FIFO_TRISTATE_OUT_EN
  localparam logic [DATA_W-1:0] IDLE_DATA = {DATA_W{1'bz}};
`else
  localparam logic [DATA_W-1:0] IDLE_DATA = '0;
`endif

  logic [WORD_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [CNT_W-1:0]  pkt_cnt;
  logic [WORD_W-1:0] rd_word;
  logic              wr_ok;
  logic              rd_ok;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[ADDR_W-1:0] == rd_ptr[ADDR_W-1:0]) &&
                   (wr_ptr[ADDR_W] != rd_ptr[ADDR_W]);
  assign wr_ok   = wr_en_0 && !full;
  assign rd_ok   = rd_en_0 && !empty;
  assign rd_word = mem[rd_ptr[ADDR_W-1:0]];

  always_ff @(posedge clk) begin
    if (rstn || soft_rst_0) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      if (wr_ok) begin
        mem[wr_ptr[ADDR_W-1:0]] <= {lfd_state, data_in};
        wr_ptr                  <= wr_ptr + PTR_W'(1);
      end
      if (rd_ok) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
    end
  end

  // A header read reloads the counter even mid-packet; the output idles once it runs out.
  always_ff @(posedge clk) begin
    if (rstn) begin
      pkt_cnt    <= '0;
      data_out_0 <= '0;
    end else if (soft_rst_0) begin
      pkt_cnt    <= '0;
      data_out_0 <= IDLE_DATA;
    end else if (rd_ok && rd_word[HDR_BIT]) begin
      pkt_cnt    <= hdr_len(rd_word[DATA_W-1:0]);
      data_out_0 <= rd_word[DATA_W-1:0];
    end else if (rd_ok && (pkt_cnt != '0)) begin
      pkt_cnt    <= pkt_cnt - CNT_W'(1);
      data_out_0 <= rd_word[DATA_W-1:0];
    end else if (pkt_cnt == '0) begin
      data_out_0 <= IDLE_DATA;
    end
  end

endmodule

// File: tb/tb_router_fifo.sv
// Directed self-checking bench for router_fifo: reset, fill, drain, simultaneous access, soft reset, wrap.
`timescale 1ns/1ps
module tb_router_fifo;
  import router_pkg::*;

  logic       clk = 1'b0;
  logic       rstn;
  logic       soft_rst_0;
  logic       wr_en_0;
  logic       rd_en_0;
  logic [7:0] data_in;
  logic       lfd_state;
  logic       empty;
  logic       full;
  logic [7:0] data_out_0;

  int n_checks = 0;
  int n_fails  = 0;

`ifdef FIFO_TRISTATE_OUT_EN
  localparam logic [7:0] IDLE = 8'hzz;
`else
  localparam logic [7:0] IDLE = 8'h00;
`endif

  always #5 clk = ~clk;

  router_fifo dut (
    .clk        (clk),
    .rstn       (rstn),
    .soft_rst_0 (soft_rst_0),
    .wr_en_0    (wr_en_0),
    .rd_en_0    (rd_en_0),
    .data_in    (data_in),
    .lfd_state  (lfd_state),
    .empty      (empty),
    .data_out_0 (data_out_0),
    .full       (full)
  );

  // One clock with the given requests; outputs are stable 1 ns after the edge.
  task automatic cycle(input logic w, input logic r, input logic [7:0] d, input logic l);
    wr_en_0 = w; rd_en_0 = r; data_in = d; lfd_state = l;
    @(posedge clk); #1;
    wr_en_0 = 1'b0; rd_en_0 = 1'b0; lfd_state = 1'b0; data_in = 8'h00;
  endtask

  task automatic pulse_soft_rst();
    soft_rst_0 = 1'b1;
    @(posedge clk); #1;
    soft_rst_0 = 1'b0;
  endtask

  task automatic test_reset();
    rstn = 1'b1; soft_rst_0 = 1'b0; wr_en_0 = 1'b0; rd_en_0 = 1'b0; data_in = 8'h00; lfd_state = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rstn = 1'b0;
    n_checks++; if (empty !== 1'b1) begin n_fails++; $display("FAIL reset_empty: got %b want 1", empty); end
    n_checks++; if (full !== 1'b0) begin n_fails++; $display("FAIL reset_full: got %b want 0", full); end
    n_checks++; if (data_out_0 !== 8'h00) begin n_fails++; $display("FAIL reset_data: got %h want 00", data_out_0); end
    cycle(1'b0, 1'b1, 8'h00, 1'b0);
    n_checks++; if (empty !== 1'b1) begin n_fails++; $display("FAIL reset_rd_empty: got %b want 1", empty); end
    n_checks++; if (data_out_0 !== IDLE) begin n_fails++; $display("FAIL reset_rd_idle: got %h want %h", data_out_0, IDLE); end
    // A single zero-length header written and read back proves rd_ptr did not move.
    cycle(1'b1, 1'b0, 8'h01, 1'b1);
    n_checks++; if (empty !== 1'b0) begin n_fails++; $display("FAIL reset_one_word: empty got %b want 0", empty); end
    cycle(1'b0, 1'b1, 8'h00, 1'b0);
    n_checks++; if (data_out_0 !== 8'h01) begin n_fails++; $display("FAIL reset_readback: got %h want 01", data_out_0); end
    n_checks++; if (empty !== 1'b1) begin n_fails++; $display("FAIL reset_readback_empty: got %b want 1", empty); end
  endtask

  logic [7:0] pkt [16];

  task automatic test_fill();
    logic [7:0] par;
    pulse_soft_rst();
    n_checks++; if (data_out_0 !== IDLE) begin n_fails++; $display("FAIL fill_softrst_idle: got %h want %h", data_out_0, IDLE); end
    pkt[0] = 8'h39;
    par = 8'h39;
    for (int i = 1; i < 15; i++) begin
      pkt[i] = 8'(8'h11 * i);
      par    = par ^ pkt[i];
    end
    pkt[15] = par;
    for (int i = 0; i < 16; i++) begin
      cycle(1'b1, 1'b0, pkt[i], (i == 0));
      if (i == 14) begin
        n_checks++; if (full !== 1'b0) begin n_fails++; $display("FAIL fill_15_full: got %b want 0", full); end
      end
    end
    n_checks++; if (full !== 1'b1) begin n_fails++; $display("FAIL fill_16_full: got %b want 1", full); end
    n_checks++; if (empty !== 1'b0) begin n_fails++; $display("FAIL fill_16_empty: got %b want 0", empty); end
    cycle(1'b1, 1'b0, 8'hEE, 1'b0);
    n_checks++; if (full !== 1'b1) begin n_fails++; $display("FAIL fill_17_full: got %b want 1", full); end
  endtask

  task automatic test_drain();
    for (int i = 0; i < 16; i++) begin
      cycle(1'b0, 1'b1, 8'h00, 1'b0);
      n_checks++; if (data_out_0 !== pkt[i]) begin n_fails++; $display("FAIL drain_data[%0d]: got %h want %h", i, data_out_0, pkt[i]); end
      if (i == 0) begin
        n_checks++; if (full !== 1'b0) begin n_fails++; $display("FAIL drain_first_full: got %b want 0", full); end
      end
      if (i == 14) begin
        n_checks++; if (empty !== 1'b0) begin n_fails++; $display("FAIL drain_15_empty: got %b want 0", empty); end
      end
    end
    n_checks++; if (empty !== 1'b1) begin n_fails++; $display("FAIL drain_16_empty: got %b want 1", empty); end
    cycle(1'b0, 1'b0, 8'h00, 1'b0);
    n_checks++; if (data_out_0 !== IDLE) begin n_fails++; $display("FAIL drain_idle: got %h want %h", data_out_0, IDLE); end
  endtask

  task automatic test_simultaneous();
    logic [7:0] seq [12];
    pulse_soft_rst();
    // Header length 11 keeps the counter nonzero through all twelve reads.
    seq[0] = 8'h2C;
    for (int i = 1; i < 12; i++) seq[i] = 8'(8'hA0 + i);
    for (int i = 0; i < 8; i++) cycle(1'b1, 1'b0, seq[i], (i == 0));
    for (int i = 0; i < 4; i++) begin
      cycle(1'b1, 1'b1, seq[8 + i], 1'b0);
      n_checks++; if (data_out_0 !== seq[i]) begin n_fails++; $display("FAIL simul_rd[%0d]: got %h want %h", i, data_out_0, seq[i]); end
    end
    n_checks++; if (empty !== 1'b0 || full !== 1'b0) begin n_fails++; $display("FAIL simul_flags: got empty=%b full=%b want 0 0", empty, full); end
    for (int i = 4; i < 12; i++) begin
      cycle(1'b0, 1'b1, 8'h00, 1'b0);
      n_checks++; if (data_out_0 !== seq[i]) begin n_fails++; $display("FAIL simul_drain[%0d]: got %h want %h", i, data_out_0, seq[i]); end
      if (i == 10) begin
        n_checks++; if (empty !== 1'b0) begin n_fails++; $display("FAIL simul_occupancy: empty got %b want 0", empty); end
      end
    end
    n_checks++; if (empty !== 1'b1) begin n_fails++; $display("FAIL simul_drained: empty got %b want 1", empty); end

    // Full: the read goes through, the write is dropped.
    pulse_soft_rst();
    for (int i = 0; i < 16; i++) cycle(1'b1, 1'b0, (i == 0) ? 8'hFC : 8'(8'h60 + i), (i == 0));
    n_checks++; if (full !== 1'b1) begin n_fails++; $display("FAIL simfull_full: got %b want 1", full); end
    cycle(1'b1, 1'b1, 8'h77, 1'b0);
    n_checks++; if (full !== 1'b0) begin n_fails++; $display("FAIL simfull_after: full got %b want 0", full); end
    n_checks++; if (data_out_0 !== 8'hFC) begin n_fails++; $display("FAIL simfull_hdr: got %h want fc", data_out_0); end
    for (int i = 1; i < 16; i++) begin
      cycle(1'b0, 1'b1, 8'h00, 1'b0);
      n_checks++; if (data_out_0 !== 8'(8'h60 + i)) begin n_fails++; $display("FAIL simfull_data[%0d]: got %h want %h", i, data_out_0, 8'(8'h60 + i)); end
    end
    n_checks++; if (empty !== 1'b1) begin n_fails++; $display("FAIL simfull_dropped: empty got %b want 1", empty); end
  endtask

  task automatic test_soft_reset();
    pulse_soft_rst();
    for (int i = 0; i < 10; i++) cycle(1'b1, 1'b0, (i == 0) ? 8'h24 : 8'(8'hC0 + i), (i == 0));
    for (int i = 0; i < 3; i++) begin
      cycle(1'b0, 1'b1, 8'h00, 1'b0);
      n_checks++; if (data_out_0 !== ((i == 0) ? 8'h24 : 8'(8'hC0 + i))) begin n_fails++; $display("FAIL soft_pre[%0d]: got %h", i, data_out_0); end
    end
    // Soft reset outranks a concurrent write.
    wr_en_0 = 1'b1; data_in = 8'h5A;
    pulse_soft_rst();
    wr_en_0 = 1'b0;
    n_checks++; if (empty !== 1'b1) begin n_fails++; $display("FAIL soft_empty: got %b want 1", empty); end
    n_checks++; if (full !== 1'b0) begin n_fails++; $display("FAIL soft_full: got %b want 0", full); end
    n_checks++; if (data_out_0 !== IDLE) begin n_fails++; $display("FAIL soft_idle: got %h want %h", data_out_0, IDLE); end
    cycle(1'b0, 1'b1, 8'h00, 1'b0);
    n_checks++; if (empty !== 1'b1 || data_out_0 !== IDLE) begin n_fails++; $display("FAIL soft_stays_idle: empty=%b data=%h want 1 %h", empty, data_out_0, IDLE); end
  endtask

  task automatic test_wrap();
    logic [7:0] exp_b;
    for (int k = 0; k < 3; k++) begin
      for (int i = 0; i < 16; i++) cycle(1'b1, 1'b0, (i == 0) ? 8'h39 : 8'(16 * k + i), (i == 0));
      n_checks++; if (full !== 1'b1 || empty !== 1'b0) begin n_fails++; $display("FAIL wrap%0d_full: full=%b empty=%b want 1 0", k, full, empty); end
      for (int i = 0; i < 16; i++) begin
        exp_b = (i == 0) ? 8'h39 : 8'(16 * k + i);
        cycle(1'b0, 1'b1, 8'h00, 1'b0);
        n_checks++; if (data_out_0 !== exp_b) begin n_fails++; $display("FAIL wrap%0d_data[%0d]: got %h want %h", k, i, data_out_0, exp_b); end
      end
      n_checks++; if (empty !== 1'b1 || full !== 1'b0) begin n_fails++; $display("FAIL wrap%0d_empty: empty=%b full=%b want 1 0", k, empty, full); end
      cycle(1'b0, 1'b0, 8'h00, 1'b0);
      n_checks++; if (data_out_0 !== IDLE) begin n_fails++; $display("FAIL wrap%0d_idle: got %h want %h", k, data_out_0, IDLE); end
    end
    n_checks++; if (hdr_dest(8'h39) !== 2'b01 || hdr_len(8'h39) !== 7'd15) begin n_fails++; $display("FAIL hdr_fields: dest=%0d len=%0d want 1 15", hdr_dest(8'h39), hdr_len(8'h39)); end
  endtask

  initial begin
    test_reset();
    test_fill();
    test_drain();
    test_simultaneous();
    test_soft_reset();
    test_wrap();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
